// File: rtl/dmem_pkg.sv
// Shared widths, state encoding and request record for the dual-port data memory.
package dmem_pkg;

    localparam int unsigned DMEM_AW    = 9;
    localparam int unsigned DMEM_DW    = 16;
    localparam int unsigned DMEM_DEPTH = 512;

    typedef enum logic {
        DM_CLEAR,
        DM_READY
    } dm_state_t;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
        logic               we;
    } dm_req_t;

endpackage

// File: rtl/dmem_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then raises dm_ready.
module dmem_clear_seq
    import dmem_pkg::*;
#(
    parameter int unsigned AW = DMEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          dm_ready
);

    dm_state_t     state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          dm_ready_q, dm_ready_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DM_CLEAR;
            clr_addr_q <= '0;
            dm_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            dm_ready_q <= dm_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        dm_ready_d = dm_ready_q;
        case (state_q)
            DM_CLEAR: begin
                clr_addr_d = clr_addr_q + AW'(1);
                // Last address written on this edge: the array is fully zeroed.
                if (clr_addr_q == '1) begin
                    state_d    = DM_READY;
                    dm_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign clr_we   = (state_q == DM_CLEAR);
    assign clr_addr = clr_addr_q;
    assign dm_ready = dm_ready_q;

endmodule

// File: rtl/dual_port_dmem.sv
// Dual-port data memory for the dual-issue CPU; p1 is later in program order.
// Define DMEM_BYPASS_EN to forward a same-cycle p0 store into a p1 load of the same address.
module dual_port_dmem
    import dmem_pkg::*;
#(
    parameter int unsigned AW    = DMEM_AW,
    parameter int unsigned DW    = DMEM_DW,
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] p0_DM_maddr,
    input  logic [DW-1:0] p0_DM_wdata,
    input  logic          p0_DM_write_mem,
    output logic [DW-1:0] p0_DM_rdata,
    input  logic [AW-1:0] p1_DM_maddr,
    input  logic [DW-1:0] p1_DM_wdata,
    input  logic          p1_DM_write_mem,
    output logic [DW-1:0] p1_DM_rdata,
    output logic          dm_ready
);

    // The request record is sized from the package, so the geometry is fixed to it.
    if (AW != DMEM_AW || DW != DMEM_DW || DEPTH != (2 ** AW)) begin : g_bad_cfg
        $error("dual_port_dmem: AW/DW must match dmem_pkg and DEPTH must equal 2**AW");
    end

    dm_req_t       req0, req1;
    logic [DW-1:0] mem_q [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          p0_we, p1_we;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;

    always_comb begin
        req0 = '{addr: p0_DM_maddr, wdata: p0_DM_wdata, we: p0_DM_write_mem};
        req1 = '{addr: p1_DM_maddr, wdata: p1_DM_wdata, we: p1_DM_write_mem};
    end

    dmem_clear_seq #(
        .AW(AW)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .dm_ready(dm_ready)
    );

    // p1 is younger, so on an address collision p0's store is squashed.
    always_comb begin
        p0_we = dm_ready && !rst && req0.we && !(req1.we && (req0.addr == req1.addr));
        p1_we = dm_ready && !rst && req1.we;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (p0_we) mem_q[req0.addr] <= req0.wdata;
            if (p1_we) mem_q[req1.addr] <= req1.wdata;
        end
    end

    always_comb begin
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        if (!dm_ready) begin
            p0_rdata_d = '0;
            p1_rdata_d = '0;
        end else begin
            if (!req0.we) p0_rdata_d = mem_q[req0.addr];
            if (!req1.we) begin
                p1_rdata_d = mem_q[req1.addr];
`ifdef DMEM_BYPASS_EN
                if (req0.we && (req0.addr == req1.addr)) p1_rdata_d = req0.wdata;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0_DM_rdata = p0_rdata_q;
    assign p1_DM_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dual_port_dmem.sv
// Scoreboard bench for dual_port_dmem: a behavioural memory model predicts rdata and dm_ready.
module tb_dual_port_dmem;
    import dmem_pkg::*;

    typedef struct packed {
        dm_req_t p0;
        dm_req_t p1;
        logic    r;
    } stim_t;

`ifdef DMEM_BYPASS_EN
    localparam logic [15:0] BYP_EXP = 16'h00AB;
`else
    localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  p0_DM_maddr = '0, p1_DM_maddr = '0;
    logic [15:0] p0_DM_wdata = '0, p1_DM_wdata = '0;
    logic        p0_DM_write_mem = 1'b0, p1_DM_write_mem = 1'b0;
    logic [15:0] p0_DM_rdata, p1_DM_rdata;
    logic        dm_ready;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [15:0] model [512];
    logic [15:0] prev0 = '0, prev1 = '0;
    logic        ready_m = 1'b0;
    int unsigned clr_cnt = 0;
    logic [15:0] exp0_q [$];
    logic [15:0] exp1_q [$];
    logic        expr_q [$];

    dual_port_dmem #(
        .AW   (9),
        .DW   (16),
        .DEPTH(512)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .p0_DM_maddr    (p0_DM_maddr),
        .p0_DM_wdata    (p0_DM_wdata),
        .p0_DM_write_mem(p0_DM_write_mem),
        .p0_DM_rdata    (p0_DM_rdata),
        .p1_DM_maddr    (p1_DM_maddr),
        .p1_DM_wdata    (p1_DM_wdata),
        .p1_DM_write_mem(p1_DM_write_mem),
        .p1_DM_rdata    (p1_DM_rdata),
        .dm_ready       (dm_ready)
    );

    always #5 clk = ~clk;

    function automatic dm_req_t ld(input logic [8:0] a);
        ld = '{addr: a, wdata: 16'h0000, we: 1'b0};
    endfunction

    function automatic dm_req_t st(input logic [8:0] a, input logic [15:0] d);
        st = '{addr: a, wdata: d, we: 1'b1};
    endfunction

    // Drive one cycle, push the model's predictions, and advance to #1 past the edge.
    task automatic drive(input stim_t s);
        logic [15:0] e0, e1;
        rst             = s.r;
        p0_DM_maddr     = s.p0.addr;
        p0_DM_wdata     = s.p0.wdata;
        p0_DM_write_mem = s.p0.we;
        p1_DM_maddr     = s.p1.addr;
        p1_DM_wdata     = s.p1.wdata;
        p1_DM_write_mem = s.p1.we;
        if (s.r || !ready_m) begin
            e0 = '0;
            e1 = '0;
        end else begin
            e0 = s.p0.we ? prev0 : model[s.p0.addr];
            e1 = s.p1.we ? prev1 : model[s.p1.addr];
`ifdef DMEM_BYPASS_EN
            if (!s.p1.we && s.p0.we && s.p0.addr == s.p1.addr) e1 = s.p0.wdata;
`endif
            if (s.p0.we) model[s.p0.addr] = s.p0.wdata;
            if (s.p1.we) model[s.p1.addr] = s.p1.wdata;
        end
        prev0 = e0;
        prev1 = e1;
        if (s.r) begin
            ready_m = 1'b0;
            clr_cnt = 0;
            for (int unsigned k = 0; k < 512; k++) model[k] = '0;
        end else if (!ready_m) begin
            clr_cnt++;
            if (clr_cnt == 512) ready_m = 1'b1;
        end
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        expr_q.push_back(ready_m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e0, e1;
        logic        er;
        stim_t       s;
        for (int unsigned i = 0; i < 515; i++) begin
            s = '{p0: ld(9'(i)), p1: ld(9'(511 - i)), r: (i == 0)};
            if (i == 513) s = '{p0: ld(9'h000), p1: ld(9'h0FF), r: 1'b0};
            if (i == 514) s = '{p0: ld(9'h1FF), p1: ld(9'h000), r: 1'b0};
            drive(s);
            e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); er = expr_q.pop_front();
            n_checks += 4;
            if (p0_DM_rdata !== e0) begin n_fails++; $display("FAIL reset p0_rdata step %0d: got %h expected %h", i, p0_DM_rdata, e0); end
            if (p1_DM_rdata !== e1) begin n_fails++; $display("FAIL reset p1_rdata step %0d: got %h expected %h", i, p1_DM_rdata, e1); end
            if (dm_ready !== er) begin n_fails++; $display("FAIL reset dm_ready step %0d: got %b expected %b", i, dm_ready, er); end
            if (dm_ready !== (i >= 512)) begin n_fails++; $display("FAIL reset ready_edge step %0d: got %b expected %b", i, dm_ready, (i >= 512)); end
        end
    endtask

    task automatic run_steps(input string name, input stim_t steps [$]);
        logic [15:0] e0, e1;
        logic        er;
        foreach (steps[i]) begin
            drive(steps[i]);
            e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front(); er = expr_q.pop_front();
            n_checks += 3;
            if (p0_DM_rdata !== e0) begin n_fails++; $display("FAIL %s p0_rdata step %0d: got %h expected %h", name, i, p0_DM_rdata, e0); end
            if (p1_DM_rdata !== e1) begin n_fails++; $display("FAIL %s p1_rdata step %0d: got %h expected %h", name, i, p1_DM_rdata, e1); end
            if (dm_ready !== er) begin n_fails++; $display("FAIL %s dm_ready step %0d: got %b expected %b", name, i, dm_ready, er); end
        end
    endtask

    task automatic test_diff_addr();
        stim_t q [$];
        q.push_back('{p0: st(9'h010, 16'h0002), p1: st(9'h011, 16'h0004), r: 1'b0});
        q.push_back('{p0: ld(9'h011), p1: ld(9'h010), r: 1'b0});
        run_steps("diff_addr", q);
        n_checks += 2;
        if (p0_DM_rdata !== 16'h0004) begin n_fails++; $display("FAIL diff_addr p0_const: got %h expected 0004", p0_DM_rdata); end
        if (p1_DM_rdata !== 16'h0002) begin n_fails++; $display("FAIL diff_addr p1_const: got %h expected 0002", p1_DM_rdata); end
    endtask

    task automatic test_same_addr_store();
        stim_t q [$];
        q.push_back('{p0: st(9'h020, 16'h1111), p1: st(9'h020, 16'h2222), r: 1'b0});
        q.push_back('{p0: ld(9'h020), p1: ld(9'h020), r: 1'b0});
        run_steps("same_store", q);
        n_checks += 2;
        if (p0_DM_rdata !== 16'h2222) begin n_fails++; $display("FAIL same_store p0_const: got %h expected 2222", p0_DM_rdata); end
        if (p1_DM_rdata !== 16'h2222) begin n_fails++; $display("FAIL same_store p1_const: got %h expected 2222", p1_DM_rdata); end
    endtask

    task automatic test_p0_store_p1_load();
        stim_t q [$];
        q.push_back('{p0: st(9'h030, 16'h00AB), p1: ld(9'h030), r: 1'b0});
        run_steps("p0st_p1ld", q);
        n_checks += 1;
        if (p1_DM_rdata !== BYP_EXP) begin n_fails++; $display("FAIL p0st_p1ld bypass: got %h expected %h", p1_DM_rdata, BYP_EXP); end
        q = {};
        q.push_back('{p0: ld(9'h030), p1: ld(9'h030), r: 1'b0});
        run_steps("p0st_p1ld_after", q);
        n_checks += 2;
        if (p0_DM_rdata !== 16'h00AB) begin n_fails++; $display("FAIL p0st_p1ld p0_later: got %h expected 00ab", p0_DM_rdata); end
        if (p1_DM_rdata !== 16'h00AB) begin n_fails++; $display("FAIL p0st_p1ld p1_later: got %h expected 00ab", p1_DM_rdata); end
    endtask

    task automatic test_p1_store_p0_load();
        stim_t q [$];
        q.push_back('{p0: ld(9'h040), p1: st(9'h040, 16'h00CD), r: 1'b0});
        run_steps("p1st_p0ld", q);
        n_checks += 1;
        if (p0_DM_rdata !== 16'h0000) begin n_fails++; $display("FAIL p1st_p0ld old: got %h expected 0000", p0_DM_rdata); end
        q = {};
        q.push_back('{p0: ld(9'h040), p1: ld(9'h041), r: 1'b0});
        run_steps("p1st_p0ld_after", q);
        n_checks += 1;
        if (p0_DM_rdata !== 16'h00CD) begin n_fails++; $display("FAIL p1st_p0ld later: got %h expected 00cd", p0_DM_rdata); end
    endtask

    task automatic test_back_to_back();
        stim_t q [$];
        for (int unsigned i = 0; i < 300; i++) begin
            q.push_back('{p0: '{addr: 9'(9'h100 + $urandom_range(0, 5)), wdata: 16'($urandom), we: 1'($urandom_range(0, 1))},
                          p1: '{addr: 9'(9'h100 + $urandom_range(0, 5)), wdata: 16'($urandom), we: 1'($urandom_range(0, 1))},
                          r: 1'b0});
        end
        run_steps("back_to_back", q);
    endtask

    task automatic test_mid_reset();
        stim_t q [$];
        q.push_back('{p0: st(9'h050, 16'h5555), p1: ld(9'h050), r: 1'b0});
        q.push_back('{p0: ld(9'h050), p1: ld(9'h011), r: 1'b0});
        run_steps("mid_reset_pre", q);
        q = {};
        q.push_back('{p0: st(9'h060, 16'h7777), p1: ld(9'h050), r: 1'b1});
        run_steps("mid_reset_edge", q);
        n_checks += 3;
        if (dm_ready !== 1'b0) begin n_fails++; $display("FAIL mid_reset ready_drop: got %b expected 0", dm_ready); end
        if (p0_DM_rdata !== 16'h0000) begin n_fails++; $display("FAIL mid_reset p0_zero: got %h expected 0000", p0_DM_rdata); end
        if (p1_DM_rdata !== 16'h0000) begin n_fails++; $display("FAIL mid_reset p1_zero: got %h expected 0000", p1_DM_rdata); end
        q = {};
        for (int unsigned i = 0; i < 512; i++) q.push_back('{p0: st(9'h050, 16'hBEEF), p1: ld(9'h060), r: 1'b0});
        q.push_back('{p0: ld(9'h050), p1: ld(9'h060), r: 1'b0});
        run_steps("mid_reset_clear", q);
        n_checks += 3;
        if (dm_ready !== 1'b1) begin n_fails++; $display("FAIL mid_reset ready_back: got %b expected 1", dm_ready); end
        if (p0_DM_rdata !== 16'h0000) begin n_fails++; $display("FAIL mid_reset p0_cleared: got %h expected 0000", p0_DM_rdata); end
        if (p1_DM_rdata !== 16'h0000) begin n_fails++; $display("FAIL mid_reset p1_cleared: got %h expected 0000", p1_DM_rdata); end
    endtask

    initial begin
        for (int unsigned k = 0; k < 512; k++) model[k] = '0;
        #2;
        test_reset();
        test_diff_addr();
        test_same_addr_store();
        test_p0_store_p1_load();
        test_p1_store_p0_load();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
